// File: rtl/mem_fake_ram.sv
// mem_fake_ram: single-port synchronous word RAM used as a stand-in
// instruction/data memory for the RISC-V CPU in simulation.
// One 32-bit word per address, 1 << ADDR_BITS words.
// Reads are registered, so data appears one cycle after the request.
//
// Optional feature: define MEM_FAKE_OOR_ZERO_EN to make addr[31:ADDR_BITS] != 0
// an out-of-range access. Such writes are dropped and such reads return zero.
// Without the macro the upper address bits are ignored, so the address aliases.
module mem_fake_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_BITS = 16,
  parameter int DEPTH     = 1 << ADDR_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              read,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  // Storage is deliberately left uninitialised.
  // Unwritten words therefore read as X in simulation.
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [DATA_W-1:0]    r_dataOut;
  logic [ADDR_BITS-1:0] w_index;
  logic                 w_upperNonZero;
  logic                 w_inRange;
  logic                 w_doWrite;
  logic                 w_doRead;

  assign w_index        = addr[ADDR_BITS-1:0];
  assign w_upperNonZero = |addr[31:ADDR_BITS];

`ifdef MEM_FAKE_OOR_ZERO_EN
  assign w_inRange = !w_upperNonZero;
`else
  // The upper bits are ignored, so every access aliases into the array.
  // The OR term keeps those bits referenced without changing the result.
  assign w_inRange = 1'b1 | w_upperNonZero;
`endif

  // Reset suppresses any write requested in the same cycle.
  assign w_doWrite = !rst && enable && !read && w_inRange;
  assign w_doRead  = enable && read;

  // Array write port. Reset only blocks the write; it never clears contents.
  always_ff @(posedge clk) begin
    if (w_doWrite) begin
      r_mem[w_index] <= data_in;
    end
  end

  // Registered read data.
  // It clears on reset, loads on a read, and otherwise holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dataOut <= '0;
    end else if (w_doRead) begin
      r_dataOut <= w_inRange ? r_mem[w_index] : '0;
    end
  end

  assign data_out = r_dataOut;

endmodule

// File: tb/tb_mem_fake_ram.sv
// tb_mem_fake_ram: self-checking bench for mem_fake_ram.
// The bench uses directed sequences, a vector table and randomised traffic.
// All expected values come from a word-array reference model of the memory.
module tb_mem_fake_ram;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        read;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int checks;
  int failures;

`ifdef MEM_FAKE_OOR_ZERO_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  // Reference model: the whole memory as a plain array, plus the expected output.
  logic [31:0] modelMem [65536];
  logic [31:0] modelOut;

  typedef struct {
    logic        en;
    logic        rd;
    logic [31:0] a;
    logic [31:0] din;
    logic [31:0] expOut;
  } vec_t;

  vec_t vecs [14];

  mem_fake_ram dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .read    (read),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, cross the rising edge, then update the model.
  // Outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic en, input logic rd,
                               input logic [31:0] a, input logic [31:0] d);
    logic oor;
    rst     = r;
    enable  = en;
    read    = rd;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    oor = OOR_EN && (a[31:16] != 16'h0);
    if (r) begin
      modelOut = 32'h0;
    end else if (en) begin
      if (rd) modelOut = oor ? 32'h0 : modelMem[a[15:0]];
      else if (!oor) modelMem[a[15:0]] = d;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp);
    checks++;
    if (data_out !== exp) begin
      failures++;
      $display("[TB] FAIL %s: data_out=%h expected=%h", name, data_out, exp);
    end
  endtask

  initial begin
    logic [31:0] k;
    logic [31:0] a;
    logic [31:0] prevK;
    checks   = 0;
    failures = 0;
    modelOut = 32'h0;

    // Reset with a write request present; the output must be zero afterwards.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3, 32'h7);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("reset_state", 32'h0);

    // Fill: mem[i] = i. The output must hold 0 throughout because nothing is read.
    for (int i = 0; i < 65536; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'(i), 32'(i));
    end
    checkOutput("hold_after_fill", 32'h0);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'd1234, 32'h0);
    checkOutput("read_1234", 32'd1234);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd65535, 32'h0);
    checkOutput("read_last", 32'd65535);

    // Back-to-back random reads.
    // After each edge the output equals the address requested before it.
    prevK = 32'd65535;
    for (int i = 0; i < 20; i++) begin
      k = 32'($urandom_range(65535));
      applyStimulus(1'b0, 1'b1, 1'b1, k, 32'h0);
      checkOutput($sformatf("rand_read%0d", i), k);
      prevK = k;
    end

    // Vector table. Expected values follow from the fill and the rules above.
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0,         32'h10};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0042, 32'hDEADBEEF,  32'h10};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0042, 32'h0,         32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0043, 32'h0,         32'h43};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'h43};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_1000, 32'h0,         32'h1000};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0,         32'h10};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         32'h10};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_FFFF, 32'h0,         32'hFFFF};
    vecs[9]  = '{1'b1, 1'b1, 32'h0001_0005, 32'h0,         OOR_EN ? 32'h0 : 32'h5};
    vecs[10] = '{1'b1, 1'b0, 32'h0001_0007, 32'hAAAA5555,  OOR_EN ? 32'h0 : 32'h5};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0007, 32'h0,         OOR_EN ? 32'h7 : 32'hAAAA5555};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         OOR_EN ? 32'h7 : 32'hAAAA5555};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0,         32'h8};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, vecs[i].en, vecs[i].rd, vecs[i].a, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
    end

    // Reset during a write: the output is cleared and the contents of mem[3] survive.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3, 32'h0);
    checkOutput("pre_reset_read3", 32'h3);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3, 32'h7);
    checkOutput("reset_clears_out", 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3, 32'h0);
    checkOutput("mem3_unchanged", 32'h3);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0001_0005, 32'h0);
    checkOutput("oor_read_0x10005", OOR_EN ? 32'h0 : 32'h5);

    // Random traffic checked against the array model.
    // Some addresses have their upper bits set.
    for (int i = 0; i < 400; i++) begin
      a = 32'($urandom_range(255));
      if ($urandom_range(3) == 0) a[31:16] = 16'($urandom_range(65535));
      applyStimulus(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), a, $urandom);
      checkOutput($sformatf("random%0d", i), modelOut);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
